i2c_txn_arbiter: RTL and testbench
==================================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one I2C controller between NUM_REQ requesters. Arbitrates round-robin, then
//  latches the winner's transaction (rw/address/data/bytesend). Pulses the controller
//  start, supervises completion with a timeout, and returns done/err to the winner.
//  Sits between the system-side clients and the single I2C controller instance.
// PARAMETERS
//  NUM_REQ        4       number of requesters (2..8)
//  ADDR_SIZE      7       I2C target address width, matches controller
//  TIMEOUT_CYCLES 200000  max clock cycles from start pulse to controller completion
// PORTS
//  clock          in   1              system clock
//  reset_n        in   1              synchronous, active-low reset
//  req            in   NUM_REQ        level request per client, held until done/err
//  req_rw         in   NUM_REQ        per-client rw bit
//  req_addr       in   NUM_REQ*ADDR   per-client address, client i at [i*ADDR_SIZE +: ADDR_SIZE]
//  req_data       in   NUM_REQ*32     per-client payload, client i at [i*32 +: 32]
//  req_bytes      in   NUM_REQ*4      per-client byte count, client i at [i*4 +: 4]
//  gnt            out  NUM_REQ        one-hot, owner of the controller
//  done           out  NUM_REQ        1-cycle success pulse to owner
//  err            out  NUM_REQ        1-cycle failure pulse to owner (NACK or timeout)
//  ctrl_init      out  1              1-cycle start pulse to controller
//  ctrl_rw        out  1              latched rw
//  ctrl_address   out  ADDR_SIZE      latched address
//  ctrl_data      out  32             latched data
//  ctrl_bytesend  out  4              latched byte count
//  ctrl_abort     out  1              1-cycle pulse, forces controller back to idle
//  ctrl_done      in   1              controller transaction complete (pulse or level)
//  ctrl_err       in   1              controller error state (level)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs 0, latched payload 0. Reset mid-transaction
//   drops the transaction silently: no done/err pulse, ctrl_abort=0.
//  States: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
//  IDLE: if |req, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   Latch the winner index and payload, go LAUNCH. If req==0, stay.
//  LAUNCH: gnt[win]=1, ctrl_init=1 for exactly this cycle, timer cleared, go WAIT.
//  WAIT: gnt held. Timer increments each cycle.
//   ctrl_err=1 -> RESP with fail. Else ctrl_done=1 -> RESP with ok.
//   Else timer==TIMEOUT_CYCLES-1 -> ctrl_abort=1 this cycle, RESP with fail.
//   If ctrl_err and ctrl_done are both set in the same cycle, err wins.
//   Timeout does not override err or done in the same cycle.
//  RESP: gnt held; done[win] (ok) or err[win] (fail) high for 1 cycle.
//   rr_ptr <= (win+1) mod NUM_REQ. Go IDLE.
//  ctrl_done/ctrl_err are ignored outside WAIT.
//  Latency: req rises in IDLE at cycle t -> ctrl_init at t+1. Best-case done at t+3.
//  Payload changes or req deassertion after latching are ignored. The transaction runs to
//   completion and the response still pulses.
//  A client must see its done/err before re-arbitration. It is never re-granted in the
//   IDLE cycle right after RESP unless it is the only requester.
//  ctrl_* payload outputs stay stable from LAUNCH through RESP.
//  Timer width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.
// STRUCTURE
//  Shared package: arbiter state encodings (IDLE/LAUNCH/WAIT/RESP) and a default
//   timeout constant, reused by other I2C sequencers.
//  One sub-module: rr_priority_pick (NUM_REQ) is combinational. Inputs req and rr_ptr,
//   outputs one-hot winner and index. FSM, payload latches and timer stay in this file.
// TESTING
//  1. Single request: req=4'b0010, addr 7'h50, data 32'hA5, ctrl_done 5 cycles after
//     init -> ctrl_init at t+1, gnt=0010, done[1] one cycle, ctrl_address=7'h50.
//  2. Round-robin: req=4'b1111 held, controller auto-completes -> grant order 0,1,2,3,0.
//  3. NACK: ctrl_err in WAIT -> err[win] one pulse, no done, next client served.
//  4. Timeout: TIMEOUT_CYCLES=16, controller silent -> ctrl_abort and err[win] on
//     cycle 16 of WAIT.
//  5. Collision: ctrl_done and ctrl_err both high -> err only. req dropped mid-WAIT ->
//     response still pulses.
//  6. Reset mid-WAIT -> all outputs 0 next cycle, rr_ptr=0, no response pulse.

Source files
------------

// File: rtl/i2c_txn_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter_pkg
//  Description : Shared definitions for the I2C transaction sequencers.
//                Arbiter state encoding and the default completion timeout.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_txn_arbiter_pkg;

    // Arbiter / sequencer phase encoding. Other I2C sequencers reuse it.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    // Clock cycles allowed from start pulse to controller completion.
    localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational round-robin pick. Returns the first set bit of
//                req when scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//  Ports       : req        - request vector
//                rr_ptr     - index with highest priority
//                win_onehot - one-hot winner (0 when no request)
//                win_idx    - winner index (0 when no request)
//                win_valid  - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_priority_pick
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         win_onehot,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       win_valid
);

    localparam int IDXW = $clog2(NUM_REQ);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    logic [IDXW:0] cand;

    // Scan from the furthest offset down to offset 0, so the candidate
    // closest to rr_ptr is the last assignment and therefore wins.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + (IDXW+1)'(off);
            if (cand >= (IDXW+1)'(NUM_REQ)) begin
                cand = cand - (IDXW+1)'(NUM_REQ);
            end
            if (req[cand[IDXW-1:0]]) begin
                win_idx   = cand[IDXW-1:0];
                win_valid = 1'b1;
            end
        end
    end

    assign win_onehot = win_valid ? (NUM_REQ'(1) << win_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Shares one I2C controller between NUM_REQ clients. Picks a
//                client round-robin, latches its transaction, pulses the
//                controller start, supervises completion with a timeout and
//                returns a one-cycle done/err pulse to the owner.
//  Ports       : clock, reset_n (sync, active-low)
//                req/req_rw/req_addr/req_data/req_bytes - client side
//                gnt/done/err                            - per-client status
//                ctrl_init/rw/address/data/bytesend/abort - to controller
//                ctrl_done/ctrl_err                      - from controller
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_txn_arbiter
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_SIZE      = 7,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]          req_data,
    input  logic [NUM_REQ*4-1:0]           req_bytes,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [NUM_REQ-1:0]             err,
    output logic                           ctrl_init,
    output logic                           ctrl_rw,
    output logic [ADDR_SIZE-1:0]           ctrl_address,
    output logic [31:0]                    ctrl_data,
    output logic [3:0]                     ctrl_bytesend,
    output logic                           ctrl_abort,
    input  logic                           ctrl_done,
    input  logic                           ctrl_err
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQ - 1);

    arb_state_e           state_q,  state_d;
    logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]      win_q,    win_d;
    logic [NUM_REQ-1:0]   owner_q,  owner_d;
    logic                 ok_q,     ok_d;
    logic [TW-1:0]        timer_q,  timer_d;
    logic                 rw_q,     rw_d;
    logic [ADDR_SIZE-1:0] addr_q,   addr_d;
    logic [31:0]          data_q,   data_d;
    logic [3:0]           bytes_q,  bytes_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDXW-1:0]      pick_idx;
    logic                 pick_valid;

    rr_priority_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        owner_d    = owner_q;
        ok_d       = ok_q;
        timer_d    = timer_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        bytes_d    = bytes_q;
        ctrl_abort = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    owner_d = pick_onehot;
                    rw_d    = req_rw[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
                    data_d  = req_data[pick_idx*32 +: 32];
                    bytes_d = req_bytes[pick_idx*4 +: 4];
                    state_d = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                timer_d = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // Saturate rather than wrap so a stuck controller can never
                // alias back to an early count.
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // Priority: controller error, then completion, then timeout.
                if (ctrl_err) begin
                    ok_d    = 1'b0;
                    state_d = ARB_RESP;
                end else if (ctrl_done) begin
                    ok_d    = 1'b1;
                    state_d = ARB_RESP;
                end else if (timer_q == TMO_LAST) begin
                    ctrl_abort = 1'b1;
                    ok_d       = 1'b0;
                    state_d    = ARB_RESP;
                end
            end
            ARB_RESP: begin
                // Start the next scan just past the client served now so it
                // cannot win again unless nobody else is asking.
                rr_ptr_d = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
                state_d  = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            owner_q  <= '0;
            ok_q     <= 1'b0;
            timer_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            bytes_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            owner_q  <= owner_d;
            ok_q     <= ok_d;
            timer_q  <= timer_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bytes_q  <= bytes_d;
        end
    end

    assign gnt           = (state_q != ARB_IDLE) ? owner_q : '0;
    assign done          = (state_q == ARB_RESP && ok_q)  ? owner_q : '0;
    assign err           = (state_q == ARB_RESP && !ok_q) ? owner_q : '0;
    assign ctrl_init     = (state_q == ARB_LAUNCH);
    assign ctrl_rw       = rw_q;
    assign ctrl_address  = addr_q;
    assign ctrl_data     = data_q;
    assign ctrl_bytesend = bytes_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_txn_arbiter
//  Description : Self-checking bench for i2c_txn_arbiter. A transaction-level
//                model predicts every output each cycle; directed scenarios
//                add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int T  = 16;

    localparam int EM_DONE   = 0;
    localparam int EM_ERR    = 1;
    localparam int EM_BOTH   = 2;
    localparam int EM_SILENT = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N-1:0]      req_rw;
    logic [N*AW-1:0]   req_addr;
    logic [N*32-1:0]   req_data;
    logic [N*4-1:0]    req_bytes;
    logic [N-1:0]      gnt, done, err;
    logic              ctrl_init, ctrl_rw, ctrl_abort;
    logic [AW-1:0]     ctrl_address;
    logic [31:0]       ctrl_data;
    logic [3:0]        ctrl_bytesend;
    logic              ctrl_done, ctrl_err;

    i2c_txn_arbiter #(
        .NUM_REQ        (N),
        .ADDR_SIZE      (AW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .req_rw        (req_rw),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_bytes     (req_bytes),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .ctrl_init     (ctrl_init),
        .ctrl_rw       (ctrl_rw),
        .ctrl_address  (ctrl_address),
        .ctrl_data     (ctrl_data),
        .ctrl_bytesend (ctrl_bytesend),
        .ctrl_abort    (ctrl_abort),
        .ctrl_done     (ctrl_done),
        .ctrl_err      (ctrl_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // ---------------- literal expectations, consumed by the checker --------
    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } lit_t;
    lit_t lit_q[$];

    int n_tests = 0;
    int n_fails = 0;

    // ---------------- controller emulator ----------------
    int emu_mode  = EM_DONE;
    int emu_delay = 1;
    int emu_cnt;

    initial begin
        ctrl_done = 1'b0;
        ctrl_err  = 1'b0;
        emu_cnt   = 0;
        forever begin
            @(negedge clock);
            if (ctrl_init === 1'b1) emu_cnt = emu_delay;
            @(posedge clock);
            #1;
            ctrl_done = 1'b0;
            ctrl_err  = 1'b0;
            if (emu_cnt > 0) begin
                emu_cnt--;
                if (emu_cnt == 0) begin
                    case (emu_mode)
                        EM_DONE: ctrl_done = 1'b1;
                        EM_ERR:  ctrl_err  = 1'b1;
                        EM_BOTH: begin ctrl_done = 1'b1; ctrl_err = 1'b1; end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // m_age counts cycles since the start pulse (0 = start cycle, k = k-th
    // cycle waiting). m_resp: 0 none, 1 success, 2 failure being reported.
    bit              m_valid = 1'b0;
    bit              m_busy;
    int              m_ptr, m_owner, m_age, m_resp, m_pick;
    logic            m_rw;
    logic [AW-1:0]   m_addr;
    logic [31:0]     m_data;
    logic [3:0]      m_bytes;

    initial forever begin
        @(posedge clock);
        if (!reset_n) begin
            m_busy = 0; m_resp = 0; m_ptr = 0; m_owner = 0; m_age = 0;
            m_rw = 0; m_addr = 0; m_data = 0; m_bytes = 0;
        end else if (m_resp != 0) begin
            m_ptr  = (m_owner + 1) % N;
            m_busy = 0;
            m_resp = 0;
        end else if (m_busy) begin
            if (m_age == 0)      m_age  = 1;
            else if (ctrl_err)   m_resp = 2;
            else if (ctrl_done)  m_resp = 1;
            else if (m_age == T) m_resp = 2;
            else                 m_age++;
        end else if (req != 0) begin
            m_pick = -1;
            for (int k = 0; k < N; k++)
                if (m_pick < 0 && req[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
            m_owner = m_pick;
            m_rw    = req_rw[m_owner];
            m_addr  = req_addr[m_owner*AW +: AW];
            m_data  = req_data[m_owner*32 +: 32];
            m_bytes = req_bytes[m_owner*4 +: 4];
            m_busy  = 1;
            m_age   = 0;
        end
        m_valid = 1'b1;
    end

    // ---------------- single compare process ----------------
    logic [N-1:0] e_gnt, e_done, e_err;
    logic         e_init, e_abort;
    int           lit_rd = 0;

    task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fails++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, a, e);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (m_valid) begin
            e_gnt   = m_busy ? N'(1 << m_owner) : '0;
            e_done  = (m_resp == 1) ? e_gnt : '0;
            e_err   = (m_resp == 2) ? e_gnt : '0;
            e_init  = m_busy && m_resp == 0 && m_age == 0;
            e_abort = m_busy && m_resp == 0 && m_age == T && !ctrl_err && !ctrl_done;
            cmp("gnt",        64'(gnt),           64'(e_gnt));
            cmp("done",       64'(done),          64'(e_done));
            cmp("err",        64'(err),           64'(e_err));
            cmp("ctrl_init",  64'(ctrl_init),     64'(e_init));
            cmp("ctrl_abort", 64'(ctrl_abort),    64'(e_abort));
            cmp("ctrl_rw",    64'(ctrl_rw),       64'(m_rw));
            cmp("ctrl_addr",  64'(ctrl_address),  64'(m_addr));
            cmp("ctrl_data",  64'(ctrl_data),     64'(m_data));
            cmp("ctrl_bytes", 64'(ctrl_bytesend), 64'(m_bytes));
        end
        while (lit_rd < lit_q.size()) begin
            cmp(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
        lit_t x;
        x.name = nm; x.act = a; x.exp = e;
        lit_q.push_back(x);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req     = '0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic wait_init(output int c);
        c = -1;
        for (int k = 0; k < 100 && c < 0; k++) begin
            @(negedge clock);
            if (ctrl_init === 1'b1) c = cyc;
        end
        if (c < 0) lit("wait_init_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_resp(output int c, output logic [N-1:0] d, output logic [N-1:0] e);
        c = -1; d = '0; e = '0;
        for (int k = 0; k < 100 && c < 0; k++) begin
            @(negedge clock);
            if ((done | err) != '0) begin
                c = cyc; d = done; e = err;
            end
        end
        if (c < 0) lit("wait_resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_abort(output int c);
        c = -1;
        for (int k = 0; k < 100 && c < 0; k++) begin
            @(negedge clock);
            if (ctrl_abort === 1'b1) c = cyc;
        end
        if (c < 0) lit("wait_abort_timeout", 64'd0, 64'd1);
    endtask

    logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int t, c, l;
        logic [N-1:0] d, e;
        reset_n = 1'b0;
        req     = '0;
        for (int i = 0; i < N; i++) begin
            req_rw[i]              = i[0];
            req_addr[i*AW +: AW]   = AW'(7'h4F + i);
            req_data[i*32 +: 32]   = 32'h0000_00A4 + 32'(i);
            req_bytes[i*4 +: 4]    = 4'(i + 1);
        end
        do_reset;

        // 1: single request, controller completes 5 cycles after start
        emu_mode = EM_DONE; emu_delay = 5;
        req = 4'b0010; t = cyc;
        wait_init(c);
        lit("t1_init_cycle", 64'(c), 64'(t + 1));
        lit("t1_gnt",        64'(gnt), 64'b0010);
        lit("t1_addr",       64'(ctrl_address), 64'h50);
        lit("t1_data",       64'(ctrl_data), 64'hA5);
        wait_resp(c, d, e);
        lit("t1_done_cycle", 64'(c), 64'(t + 7));
        lit("t1_done",       64'(d), 64'b0010);
        lit("t1_err",        64'(e), 64'b0000);
        tick; req = '0; repeat (3) tick;

        // 2: all clients requesting, fair rotation
        do_reset;
        emu_delay = 1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_init(c);
            lit($sformatf("t2_grant%0d", i), 64'(gnt), 64'(exp_rr[i]));
        end
        tick; req = '0; repeat (6) tick;

        // 3: NACK, then the next client is served
        do_reset;
        emu_mode = EM_ERR; emu_delay = 2;
        req = 4'b0101;
        wait_init(c);
        lit("t3_first_gnt", 64'(gnt), 64'b0001);
        wait_resp(c, d, e);
        lit("t3_err",  64'(e), 64'b0001);
        lit("t3_done", 64'(d), 64'b0000);
        wait_init(c);
        lit("t3_next_gnt", 64'(gnt), 64'b0100);
        emu_mode = EM_DONE;
        wait_resp(c, d, e);
        lit("t3_next_done", 64'(d), 64'b0100);
        tick; req = '0; repeat (4) tick;

        // 4: silent controller, timeout on the 16th waiting cycle
        do_reset;
        emu_mode = EM_SILENT;
        req = 4'b1000;
        wait_init(l);
        wait_abort(c);
        lit("t4_abort_cycle", 64'(c), 64'(l + 16));
        lit("t4_abort_gnt",   64'(gnt), 64'b1000);
        @(negedge clock);
        lit("t4_err",  64'(err),  64'b1000);
        lit("t4_done", 64'(done), 64'b0000);
        tick; req = '0; repeat (3) tick;

        // 5a: done and err together -> err only
        do_reset;
        emu_mode = EM_BOTH; emu_delay = 3;
        req = 4'b0100;
        wait_resp(c, d, e);
        lit("t5_collide_err",  64'(e), 64'b0100);
        lit("t5_collide_done", 64'(d), 64'b0000);
        tick; req = '0; repeat (2) tick;
        // 5b: request and payload change mid-wait are ignored
        emu_mode = EM_DONE; emu_delay = 4;
        req = 4'b0001;
        wait_init(l);
        tick; tick;
        req = '0;
        req_addr[0 +: AW] = 7'h11;
        wait_resp(c, d, e);
        lit("t5_drop_cycle", 64'(c), 64'(l + 5));
        lit("t5_drop_done",  64'(d), 64'b0001);
        repeat (2) tick;

        // 6: reset in the middle of a wait
        do_reset;
        emu_mode = EM_DONE; emu_delay = 1;
        req = 4'b0010;
        wait_resp(c, d, e);
        tick; req = '0;
        emu_mode = EM_SILENT;
        req = 4'b0100;
        wait_init(c);
        tick; tick;
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        lit("t6_gnt",   64'(gnt), 64'd0);
        lit("t6_init",  64'(ctrl_init), 64'd0);
        lit("t6_abort", 64'(ctrl_abort), 64'd0);
        lit("t6_resp",  64'(done | err), 64'd0);
        lit("t6_addr",  64'(ctrl_address), 64'd0);
        lit("t6_data",  64'(ctrl_data), 64'd0);
        tick;
        reset_n  = 1'b1;
        emu_mode = EM_DONE;
        req = 4'b0110;
        wait_init(c);
        lit("t6_ptr_reset_gnt", 64'(gnt), 64'b0010);
        wait_resp(c, d, e);
        lit("t6_after_done", 64'(d), 64'b0010);
        tick; req = '0; repeat (3) tick;

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
